ascon_tx_framer: RTL and testbench
==================================

# ascon_tx_framer

Downstream stage of the ASCON transmitter: captures one encrypted record (nonce, 128-bit ciphertext, 128-bit tag) in a single handshake and serialises it as a byte stream for the link layer. Each frame is a sync byte, a length byte, the 48 payload bytes and an XOR checksum byte. Output uses a valid/ready byte handshake, so the link can apply arbitrary backpressure.

## Interface
- SYNC_BYTE, 8'hA5, first byte of every frame
- LEN_BYTE, 8'h30, second byte of every frame (payload byte count, 48)
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- load_valid  in  1  record on n0..tag1 is valid
- load_ready  out  1  framer idle and able to accept a record
- n0, n1  in  64 each  nonce words from transmitter
- ct0, ct1  in  64 each  ciphertext words (transmitter out0, out1)
- tag0, tag1  in  64 each  tag words
- byte_out  out  8  current frame byte
- byte_valid  out  1  byte_out holds a frame byte
- byte_ready  in  1  sink accepts byte_out this cycle
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after checksum byte transferred

## Operation
- States: IDLE, SEND.
- Reset values: state IDLE, load_ready=1, byte_valid=0, byte_out=8'h00, busy=0, frame_done=0, byte index=0, checksum=0.
- IDLE: load_ready=1. On load_valid && load_ready, all six words are registered into a 384-bit payload register; state goes to SEND; index=0; checksum=0.
- SEND: byte_valid=1, busy=1, load_ready=0. byte_out by index:
  - 0: SYNC_BYTE
  - 1: LEN_BYTE
  - 2..49: payload bytes in order n0, n1, ct0, ct1, tag0, tag1, each word MSB byte first
  - 50: checksum
- Transfer occurs on any edge with byte_valid && byte_ready. Index advances only on transfer.
- Checksum is the XOR of the 48 payload bytes only; SYNC and LEN are excluded. It is accumulated on each payload transfer.
- On transfer of index 50: state goes to IDLE, frame_done=1 for exactly the next cycle, byte_valid=0, load_ready=1.
- load_valid during SEND is ignored. No capture occurs and input words are not sampled.
- Input words are sampled only on the accepting edge. Later changes to them do not affect the frame in flight.

## Timing
- Load accepted at edge k: byte_valid=1 with SYNC from cycle k+1.
- With byte_ready held high, one byte is transferred per cycle and the frame occupies 51 cycles, k+1..k+51.
- frame_done and load_ready are high in cycle k+52.
- A load accepted in the frame_done cycle starts the next frame one cycle later. The minimum inter-frame gap is one cycle with byte_valid=0.
- Backpressure: while byte_valid && !byte_ready, byte_out and index hold stable with no limit on the stall length. byte_valid never drops mid-frame.
- rst asserted in any cycle, including mid-frame or together with load_valid, takes priority. The next cycle shows reset values, the partial frame is discarded and no frame_done is issued.
- Index never exceeds 50. There is no wrap: return to IDLE is the only exit from SEND.

## Test plan
- Reset, then load n0=64'h369C801F3AE8D0EA, n1=64'h9BF367D58FD211FF, ct0=ct1=64'h1234567890abcdef, tag0=tag1=0, with byte_ready=1. Required: 51 bytes, starting A5 30 36 9C 80 1F ..., bytes 34..49 = 00, checksum 8'hB4, and frame_done exactly one cycle after the last byte.
- All-zero record. Required: A5 30, then 48×00, then checksum 00; load_ready returns to 1 at cycle k+52.
- Same record as the first scenario with byte_ready toggled pseudo-randomly. Required: the byte sequence is identical to the first scenario, byte_out is stable during every stall, and byte_valid stays high until the checksum byte is transferred.
- load_valid pulsed with different words at byte index 10. Required: ignored, and the frame bytes are unchanged.
- rst asserted at byte index 20 while byte_valid=1. Required: the next cycle has byte_valid=0, load_ready=1 and no frame_done; a fresh load then produces a complete correct frame starting with A5.
- Back-to-back loads with load_valid held high. Required: the second frame's SYNC appears two cycles after the first frame's checksum transfer (frame_done cycle, then SYNC).

Source files
------------

// File: rtl/ascon_tx_framer_if.sv
// ASCON transmitter framer bus: record load handshake
// plus the byte-stream valid/ready link side.
interface ascon_tx_framer_if;
   logic        load_valid;
   logic        load_ready;
   logic [63:0] n0;
   logic [63:0] n1;
   logic [63:0] ct0;
   logic [63:0] ct1;
   logic [63:0] tag0;
   logic [63:0] tag1;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready;
   logic        busy;
   logic        frame_done;

   modport master (
      output load_valid,
      output n0, n1, ct0, ct1, tag0, tag1,
      output byte_ready,
      input  load_ready,
      input  byte_out,
      input  byte_valid,
      input  busy,
      input  frame_done
   );

   modport slave (
      input  load_valid,
      input  n0, n1, ct0, ct1, tag0, tag1,
      input  byte_ready,
      output load_ready,
      output byte_out,
      output byte_valid,
      output busy,
      output frame_done
   );
endinterface

// File: rtl/ascon_tx_framer.sv
// ASCON tx framer: captures one encrypted record and sends
// SYNC, LEN, 48 payload bytes and an XOR checksum byte.
module ascon_tx_framer (
   input  logic             clk,
   input  logic             rst,
   ascon_tx_framer_if.slave bus
);
   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] LEN_BYTE  = 8'h30;
   localparam logic [5:0] LAST_IDX  = 6'd50;
   localparam logic [5:0] FIRST_PAY = 6'd2;

   typedef enum logic {IDLE, SEND} state_t;

   state_t       state_q, state_d;
   logic [5:0]   idx_q, idx_d;
   logic [383:0] pay_q, pay_d;
   logic [7:0]   csum_q, csum_d;
   logic         done_q, done_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         pay_q   <= '0;
         csum_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pay_q   <= pay_d;
         csum_q  <= csum_d;
         done_q  <= done_d;
      end
   end

   assign bus.frame_done = done_q;

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      pay_d          = pay_q;
      csum_d         = csum_q;
      done_d         = 1'b0;
      bus.load_ready = 1'b0;
      bus.byte_valid = 1'b0;
      bus.busy       = 1'b0;
      bus.byte_out   = 8'h00;
      unique case (state_q)
         IDLE: begin
            bus.load_ready = 1'b1;
            if (bus.load_valid) begin
               pay_d   = {bus.n0, bus.n1,
                          bus.ct0, bus.ct1,
                          bus.tag0, bus.tag1};
               idx_d   = '0;
               csum_d  = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            bus.byte_valid = 1'b1;
            bus.busy       = 1'b1;
            unique case (1'b1)
               idx_q == 6'd0:     bus.byte_out = SYNC_BYTE;
               idx_q == 6'd1:     bus.byte_out = LEN_BYTE;
               idx_q == LAST_IDX: bus.byte_out = csum_q;
               default:           bus.byte_out = pay_q[383:376];
            endcase
            if (bus.byte_ready) begin
               // payload is shifted out MSB-first so the head
               // byte is always pay_q[383:376]
               if (idx_q >= FIRST_PAY && idx_q < LAST_IDX) begin
                  csum_d = csum_q ^ pay_q[383:376];
                  pay_d  = {pay_q[375:0], 8'h00};
               end
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
         end
      endcase
   end
endmodule

// File: tb/tb_ascon_tx_framer.sv
// Directed bench for ascon_tx_framer: vector table of records
// plus hand sequences for reset mid-frame and back-to-back.
module tb_ascon_tx_framer;
   logic clk;
   logic rst;
   int   tests;
   int   fails;

   ascon_tx_framer_if bus ();

   ascon_tx_framer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0][63:0] w;
      logic             rnd;
      logic             inject;
      logic [7:0]       csum;
      logic [7:0]       b2;
      logic [7:0]       b49;
   } vec_t;

   vec_t       tbl [7];
   logic [7:0] got [51];
   logic [7:0] exp_b [51];

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_vec(input int i,
                          input logic [63:0] a, b, c, d, e, f,
                          input logic rnd, inj,
                          input logic [7:0] cs, b2, b49);
      tbl[i].w[0]   = a;
      tbl[i].w[1]   = b;
      tbl[i].w[2]   = c;
      tbl[i].w[3]   = d;
      tbl[i].w[4]   = e;
      tbl[i].w[5]   = f;
      tbl[i].rnd    = rnd;
      tbl[i].inject = inj;
      tbl[i].csum   = cs;
      tbl[i].b2     = b2;
      tbl[i].b49    = b49;
   endtask

   task automatic build_exp(input vec_t v);
      logic [7:0]  cs;
      logic [63:0] wd;
      cs       = 8'h00;
      exp_b[0] = 8'hA5;
      exp_b[1] = 8'h30;
      for (int w = 0; w < 6; w++) begin
         wd = v.w[w];
         for (int b = 0; b < 8; b++) begin
            exp_b[2 + 8*w + b] = wd[63 - 8*b -: 8];
            cs = cs ^ wd[63 - 8*b -: 8];
         end
      end
      exp_b[50] = cs;
   endtask

   task automatic drive_words(input vec_t v);
      bus.n0   = v.w[0];
      bus.n1   = v.w[1];
      bus.ct0  = v.w[2];
      bus.ct1  = v.w[3];
      bus.tag0 = v.w[4];
      bus.tag1 = v.w[5];
   endtask

   task automatic scramble();
      bus.n0   = {$urandom, $urandom};
      bus.n1   = {$urandom, $urandom};
      bus.ct0  = {$urandom, $urandom};
      bus.ct1  = {$urandom, $urandom};
      bus.tag0 = {$urandom, $urandom};
      bus.tag1 = {$urandom, $urandom};
   endtask

   task automatic run_frame(input vec_t v, input string tag);
      int         nb;
      int         cyc;
      int         bad;
      int         unstable;
      int         mism;
      logic       stall;
      logic [7:0] held;
      bit         inj_done;
      for (int i = 0; i < 51; i++) got[i] = 8'hxx;
      build_exp(v);
      drive_words(v);
      bus.load_valid = 1'b1;
      bus.byte_ready = 1'b0;
      @(negedge clk);
      chk({tag, " load_ready_idle"}, 64'(bus.load_ready), 64'd1);
      @(posedge clk); #1;
      bus.load_valid = 1'b0;
      scramble();
      nb = 0; cyc = 0; bad = 0; unstable = 0;
      stall = 1'b0; held = 8'h00; inj_done = 1'b0;
      while (nb < 51 && cyc < 1000) begin
         bus.byte_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (v.inject && nb == 10 && !inj_done) begin
            bus.load_valid = 1'b1;
            scramble();
            inj_done = 1'b1;
         end else begin
            bus.load_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
         if (!bus.byte_valid || !bus.busy ||
             bus.load_ready || bus.frame_done) bad++;
         if (stall && bus.byte_out !== held) unstable++;
         if (bus.byte_valid && bus.byte_ready) begin
            got[nb] = bus.byte_out;
            nb++;
            stall = 1'b0;
         end else begin
            stall = 1'b1;
            held  = bus.byte_out;
         end
         @(posedge clk); #1;
      end
      bus.load_valid = 1'b0;
      bus.byte_ready = 1'b1;
      chk({tag, " byte_count"}, 64'(nb), 64'd51);
      if (!v.rnd) chk({tag, " frame_cycles"}, 64'(cyc), 64'd51);
      chk({tag, " ctl_bad"}, 64'(bad), 64'd0);
      chk({tag, " stall_unstable"}, 64'(unstable), 64'd0);
      mism = 0;
      for (int i = 0; i < 51; i++)
         if (got[i] !== exp_b[i]) mism++;
      chk({tag, " byte_mismatches"}, 64'(mism), 64'd0);
      chk({tag, " sync"}, 64'(got[0]), 64'hA5);
      chk({tag, " len"}, 64'(got[1]), 64'h30);
      chk({tag, " byte2"}, 64'(got[2]), 64'(v.b2));
      chk({tag, " byte49"}, 64'(got[49]), 64'(v.b49));
      chk({tag, " checksum"}, 64'(got[50]), 64'(v.csum));
      @(negedge clk);
      chk({tag, " done_pulse"}, 64'(bus.frame_done), 64'd1);
      chk({tag, " done_load_ready"}, 64'(bus.load_ready), 64'd1);
      chk({tag, " done_byte_valid"}, 64'(bus.byte_valid), 64'd0);
      chk({tag, " done_busy"}, 64'(bus.busy), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " done_cleared"}, 64'(bus.frame_done), 64'd0);
      chk({tag, " idle_valid"}, 64'(bus.byte_valid), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int   c1;
      int   c2;
      int   nt;
      int   done_at;
      vec_t alt;

      tests = 0;
      fails = 0;
      rst = 1'b1;
      bus.load_valid = 1'b0;
      bus.byte_ready = 1'b0;
      bus.n0 = '0; bus.n1 = '0; bus.ct0 = '0;
      bus.ct1 = '0; bus.tag0 = '0; bus.tag1 = '0;

      set_vec(0, 64'h369C801F3AE8D0EA, 64'h9BF367D58FD211FF,
              64'h1234567890abcdef, 64'h1234567890abcdef,
              64'h0, 64'h0, 1'b0, 1'b0, 8'hB4, 8'h36, 8'h00);
      set_vec(1, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
              1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      set_vec(2, 64'hFF00000000000000, 64'h0, 64'h0, 64'h0,
              64'h0, 64'h0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00);
      set_vec(3, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
              64'h0000000000000001, 1'b0, 1'b0,
              8'h01, 8'h00, 8'h01);
      set_vec(4, 64'h0102030405060708, 64'h0, 64'h0, 64'h0,
              64'h0, 64'h0, 1'b0, 1'b0, 8'h08, 8'h01, 8'h00);
      set_vec(5, 64'h369C801F3AE8D0EA, 64'h9BF367D58FD211FF,
              64'h1234567890abcdef, 64'h1234567890abcdef,
              64'h0, 64'h0, 1'b1, 1'b0, 8'hB4, 8'h36, 8'h00);
      set_vec(6, 64'h369C801F3AE8D0EA, 64'h9BF367D58FD211FF,
              64'h1234567890abcdef, 64'h1234567890abcdef,
              64'h0, 64'h0, 1'b0, 1'b1, 8'hB4, 8'h36, 8'h00);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst load_ready", 64'(bus.load_ready), 64'd1);
      chk("rst byte_valid", 64'(bus.byte_valid), 64'd0);
      chk("rst byte_out", 64'(bus.byte_out), 64'h00);
      chk("rst busy", 64'(bus.busy), 64'd0);
      chk("rst frame_done", 64'(bus.frame_done), 64'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++)
         run_frame(tbl[i], $sformatf("vec%0d", i));

      // reset (with a competing load) at byte index 20
      build_exp(tbl[0]);
      drive_words(tbl[0]);
      bus.load_valid = 1'b1;
      bus.byte_ready = 1'b1;
      @(posedge clk); #1;
      bus.load_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      @(negedge clk);
      chk("mid idx20 byte", 64'(bus.byte_out), 64'(exp_b[20]));
      alt = tbl[2];
      drive_words(alt);
      bus.load_valid = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.load_valid = 1'b0;
      @(negedge clk);
      chk("mid rst byte_valid", 64'(bus.byte_valid), 64'd0);
      chk("mid rst load_ready", 64'(bus.load_ready), 64'd1);
      chk("mid rst frame_done", 64'(bus.frame_done), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid rst no_done", 64'(bus.frame_done), 64'd0);
      chk("mid rst idle", 64'(bus.byte_valid), 64'd0);
      @(posedge clk); #1;
      run_frame(tbl[0], "post_rst");

      // back-to-back with load_valid held high
      drive_words(tbl[0]);
      bus.load_valid = 1'b1;
      bus.byte_ready = 1'b1;
      c1 = -1; c2 = -1; nt = 0; done_at = -1;
      for (int c = 0; c < 200 && c2 < 0; c++) begin
         @(negedge clk);
         if (bus.frame_done && c1 >= 0 && done_at < 0) done_at = c;
         if (bus.byte_valid && bus.byte_ready) begin
            nt++;
            if (nt == 51) c1 = c;
            if (nt == 52) begin
               c2 = c;
               chk("b2b second sync", 64'(bus.byte_out), 64'hA5);
            end
         end
         @(posedge clk); #1;
      end
      bus.load_valid = 1'b0;
      chk("b2b found", 64'(c2 >= 0 && c1 >= 0), 64'd1);
      chk("b2b sync gap", 64'(c2 - c1), 64'd2);
      chk("b2b done cycle", 64'(done_at - c1), 64'd1);
      done_at = -1;
      for (int c = 0; c < 200 && done_at < 0; c++) begin
         @(negedge clk);
         if (bus.frame_done) done_at = c;
         @(posedge clk); #1;
      end
      chk("b2b second done", 64'(done_at >= 0), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
